control_unit: RTL

Multi-cycle sequencer for the 16-bit CPU datapath. It decodes the 5-bit opcode and status flags returned by the datapath. It drives every datapath mux select and register write enable. It runs a request/ready handshake with instruction/data memory, so one instruction is fetched, decoded, executed and written back per pass through a small FSM.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath/memory side: decoded
// opcode, flags and memory ready in; every select, enable and status pulse out.
interface control_unit_if #(
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 5
);
    logic [OPCODE_SIZE-1:0] opcode;
    logic [WORD_SIZE-1:0]   status_reg;
    logic                   mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic [1:0] ALU_in2_mux;
    logic [1:0] PC_mux;
    logic [1:0] memory_addr_mux;
    logic [1:0] data_in_mux;
    logic       mem_out_mux;
    logic       reg_buff1_write;
    logic       reg_buff2_write;
    logic       status_reg_write;
    logic       ALU_out_write;
    logic       reg_write;
    logic       PC_write;
    logic       IR_write;
    logic       halted;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, status_reg, mem_ready,
        output mem_req, mem_we, ALU_in2_mux, PC_mux, memory_addr_mux, data_in_mux,
               mem_out_mux, reg_buff1_write, reg_buff2_write, status_reg_write,
               ALU_out_write, reg_write, PC_write, IR_write, halted, retire, illegal
    );

    modport slave (
        output opcode, status_reg, mem_ready,
        input  mem_req, mem_we, ALU_in2_mux, PC_mux, memory_addr_mux, data_in_mux,
               mem_out_mux, reg_buff1_write, reg_buff2_write, status_reg_write,
               ALU_out_write, reg_write, PC_write, IR_write, halted, retire, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU: FETCH/DECODE/EXEC/MEM/WB/HALT with a
// request/ready memory handshake; controls are decoded from state, opcode and flags.
module control_unit #(
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master cu_bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] alu_in2_mux;
        logic [1:0] pc_mux;
        logic [1:0] memory_addr_mux;
        logic [1:0] data_in_mux;
        logic       mem_out_mux;
        logic       reg_buff1_write;
        logic       reg_buff2_write;
        logic       status_reg_write;
        logic       alu_out_write;
        logic       reg_write;
        logic       pc_write;
        logic       ir_write;
        logic       halted;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP    = OPCODE_SIZE'(5'b00000);
    localparam logic [OPCODE_SIZE-1:0] OP_ALU_RR = OPCODE_SIZE'(5'b00001);
    localparam logic [OPCODE_SIZE-1:0] OP_ALU_RI = OPCODE_SIZE'(5'b00010);
    localparam logic [OPCODE_SIZE-1:0] OP_LDI    = OPCODE_SIZE'(5'b00011);
    localparam logic [OPCODE_SIZE-1:0] OP_LD     = OPCODE_SIZE'(5'b00100);
    localparam logic [OPCODE_SIZE-1:0] OP_ST     = OPCODE_SIZE'(5'b00101);
    localparam logic [OPCODE_SIZE-1:0] OP_JMP    = OPCODE_SIZE'(5'b00110);
    localparam logic [OPCODE_SIZE-1:0] OP_JR     = OPCODE_SIZE'(5'b00111);
    localparam logic [OPCODE_SIZE-1:0] OP_BZ     = OPCODE_SIZE'(5'b01000);
    localparam logic [OPCODE_SIZE-1:0] OP_BNZ    = OPCODE_SIZE'(5'b01001);
    localparam logic [OPCODE_SIZE-1:0] OP_BC     = OPCODE_SIZE'(5'b01010);
    localparam logic [OPCODE_SIZE-1:0] OP_CALL   = OPCODE_SIZE'(5'b01011);
    localparam logic [OPCODE_SIZE-1:0] OP_HALT   = OPCODE_SIZE'(5'b11111);

    state_t state_q;
    state_t state_d;
    logic   run_q;
    ctrl_t  ctrl_raw_s;
    ctrl_t  ctrl_s;
    logic   flag_z_s;
    logic   flag_c_s;
    logic [WORD_SIZE-3:0] unused_status_s;

    // Branch condition for the three conditional branch opcodes.
    function automatic logic branch_taken(
        input logic [OPCODE_SIZE-1:0] op,
        input logic                   z,
        input logic                   c
    );
        case (op)
            OP_BZ:   return z;
            OP_BNZ:  return !z;
            OP_BC:   return c;
            default: return 1'b0;
        endcase
    endfunction

    assign flag_z_s        = cu_bus.status_reg[0];
    assign flag_c_s        = cu_bus.status_reg[1];
    assign unused_status_s = cu_bus.status_reg[WORD_SIZE-1:2];

    // Next-state and raw control decode from state, opcode, flags and mem_ready.
    always_comb begin
        ctrl_raw_s = '0;
        state_d    = state_q;
        case (state_q)
            ST_FETCH: begin
                ctrl_raw_s.mem_req         = 1'b1;
                ctrl_raw_s.memory_addr_mux = 2'd0;
                if (cu_bus.mem_ready) begin
                    ctrl_raw_s.ir_write = 1'b1;
                    ctrl_raw_s.pc_write = 1'b1;
                    ctrl_raw_s.pc_mux   = 2'd0;
                    state_d             = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ctrl_raw_s.reg_buff1_write = 1'b1;
                ctrl_raw_s.reg_buff2_write = 1'b1;
                if (cu_bus.opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (cu_bus.opcode)
                    OP_NOP: begin
                        ctrl_raw_s.retire = 1'b1;
                    end
                    OP_ALU_RR, OP_ALU_RI: begin
                        ctrl_raw_s.alu_in2_mux      = (cu_bus.opcode == OP_ALU_RI) ? 2'd1 : 2'd0;
                        ctrl_raw_s.alu_out_write    = 1'b1;
                        ctrl_raw_s.status_reg_write = 1'b1;
                        state_d                     = ST_WB;
                    end
                    OP_LDI: begin
                        ctrl_raw_s.reg_write   = 1'b1;
                        ctrl_raw_s.data_in_mux = 2'd2;
                        ctrl_raw_s.retire      = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        state_d = ST_MEM;
                    end
                    OP_JMP: begin
                        ctrl_raw_s.pc_write = 1'b1;
                        ctrl_raw_s.pc_mux   = 2'd1;
                        ctrl_raw_s.retire   = 1'b1;
                    end
                    OP_JR: begin
                        ctrl_raw_s.pc_write = 1'b1;
                        ctrl_raw_s.pc_mux   = 2'd2;
                        ctrl_raw_s.retire   = 1'b1;
                    end
                    OP_BZ, OP_BNZ, OP_BC: begin
                        // An untaken branch keeps the PC+1 already written in FETCH.
                        if (branch_taken(cu_bus.opcode, flag_z_s, flag_c_s)) begin
                            ctrl_raw_s.pc_write = 1'b1;
                            ctrl_raw_s.pc_mux   = 2'd1;
                        end else begin
                            ctrl_raw_s.pc_write = 1'b0;
                        end
                        ctrl_raw_s.retire = 1'b1;
                    end
                    OP_CALL: begin
                        ctrl_raw_s.reg_write   = 1'b1;
                        ctrl_raw_s.data_in_mux = 2'd3;
                        ctrl_raw_s.pc_write    = 1'b1;
                        ctrl_raw_s.pc_mux      = 2'd1;
                        ctrl_raw_s.retire      = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        ctrl_raw_s.illegal = 1'b1;
                        ctrl_raw_s.retire  = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl_raw_s.mem_req         = 1'b1;
                ctrl_raw_s.memory_addr_mux = 2'd1;
                if (cu_bus.opcode == OP_ST) begin
                    ctrl_raw_s.mem_we      = 1'b1;
                    ctrl_raw_s.mem_out_mux = 1'b0;
                end else begin
                    ctrl_raw_s.mem_we = 1'b0;
                end
                if (cu_bus.mem_ready) begin
                    ctrl_raw_s.retire = 1'b1;
                    if (cu_bus.opcode == OP_LD) begin
                        ctrl_raw_s.reg_write   = 1'b1;
                        ctrl_raw_s.data_in_mux = 2'd1;
                    end else begin
                        ctrl_raw_s.reg_write = 1'b0;
                    end
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                ctrl_raw_s.reg_write   = 1'b1;
                ctrl_raw_s.data_in_mux = 2'd0;
                ctrl_raw_s.retire      = 1'b1;
                state_d                = ST_FETCH;
            end
            ST_HALT: begin
                ctrl_raw_s.halted = 1'b1;
                state_d           = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Controls stay at zero from reset assertion until the first edge after release.
    always_comb begin
        if (run_q) begin
            ctrl_s = ctrl_raw_s;
        end else begin
            ctrl_s = '0;
        end
    end

    // Sequencer state; run_q marks the first active cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
        end else if (run_q) begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_q;
            run_q   <= 1'b1;
        end
    end

    assign cu_bus.mem_req          = ctrl_s.mem_req;
    assign cu_bus.mem_we           = ctrl_s.mem_we;
    assign cu_bus.ALU_in2_mux      = ctrl_s.alu_in2_mux;
    assign cu_bus.PC_mux           = ctrl_s.pc_mux;
    assign cu_bus.memory_addr_mux  = ctrl_s.memory_addr_mux;
    assign cu_bus.data_in_mux      = ctrl_s.data_in_mux;
    assign cu_bus.mem_out_mux      = ctrl_s.mem_out_mux;
    assign cu_bus.reg_buff1_write  = ctrl_s.reg_buff1_write;
    assign cu_bus.reg_buff2_write  = ctrl_s.reg_buff2_write;
    assign cu_bus.status_reg_write = ctrl_s.status_reg_write;
    assign cu_bus.ALU_out_write    = ctrl_s.alu_out_write;
    assign cu_bus.reg_write        = ctrl_s.reg_write;
    assign cu_bus.PC_write         = ctrl_s.pc_write;
    assign cu_bus.IR_write         = ctrl_s.ir_write;
    assign cu_bus.halted           = ctrl_s.halted;
    assign cu_bus.retire           = ctrl_s.retire;
    assign cu_bus.illegal          = ctrl_s.illegal;

endmodule
